fifo_nibble_drain: RTL and testbench
====================================

Name: fifo_nibble_drain

Overview:
- Read-side controller for the 4-bit x 256 embedded-block-RAM LPM FIFO.
- Pulls nibbles through the FIFO read port (RdReq/Q/Empty/UsedW) and packs nibble pairs into bytes, low nibble first.
- Emits the bytes as bursts on a valid/ready byte stream feeding the downstream serial/transmit logic.
- The FIFO write side stays with the existing producer.

Parameters:
- WIDTH, 4, FIFO data width; fixed, packing requires 4.
- AW, 8, FIFO UsedW width (depth 256).
- BURST_LEN, 16, maximum bytes per burst.
- THRESH, 32, UsedW level (nibbles) that starts a full burst; must be >= 2*BURST_LEN.
- TIMEOUT, 64, idle cycles before auto-flush (only with the optional feature).

Ports:
- Clock  in  1  system clock, rising edge.
- Aclr_n  in  1  asynchronous active-low reset.
- FifoQ  in  4  FIFO read data; valid the cycle after RdReq is sampled high.
- FifoEmpty  in  1  FIFO empty flag.
- FifoUsedW  in  8  FIFO fill level in nibbles.
- FifoRdReq  out  1  FIFO read request, one nibble per asserted cycle.
- Flush  in  1  level; drain whatever is present even if below THRESH.
- ByteOut  out  8  packed byte {high nibble, low nibble}.
- ByteValid  out  1  ByteOut valid.
- ByteReady  in  1  downstream accepts when ByteValid && ByteReady.
- ByteLast  out  1  marks final byte of a burst, qualified by ByteValid.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (Aclr_n low, asynchronous): state IDLE.
  - FifoRdReq, ByteValid, ByteLast, Busy all 0.
  - ByteOut = 8'h00; remaining count = 0.
  - Reset mid-burst abandons the burst. Nibbles already read are lost; the FIFO is not rewound.
- States:
  - IDLE, REQ_LO, REQ_HI, CAP_HI, PRESENT.
  - A nibble-only path REQ_LO -> CAP_LO -> PRESENT serves the odd-nibble case.
- IDLE start conditions, evaluated each cycle:
  - UsedW >= THRESH: latch Count = BURST_LEN, go REQ_LO.
  - Else if Flush and UsedW >= 1: latch Count = min(ceil(UsedW/2), BURST_LEN), and Odd = (UsedW < 2*BURST_LEN) && UsedW[0]. Go REQ_LO.
  - Else stay in IDLE.
- REQ_LO:
  - Assert FifoRdReq only if !FifoEmpty; otherwise stall in REQ_LO with RdReq 0.
  - On a read, go REQ_HI, or CAP_LO if this is the last byte and Odd.
- REQ_HI:
  - Capture FifoQ into the low nibble.
  - Assert FifoRdReq if !FifoEmpty, then go CAP_HI.
  - If FifoEmpty, hold the captured nibble and stall in REQ_HI with RdReq 0.
- CAP_HI: capture FifoQ into the high nibble, go PRESENT.
- CAP_LO: capture FifoQ into the low nibble, set high nibble = 4'h0, go PRESENT.
- PRESENT:
  - ByteValid = 1; ByteLast = (Count == 1).
  - ByteOut stays stable until the handshake completes.
  - On handshake: Count decrements; Count becomes 0 -> IDLE, else -> REQ_LO.
  - ByteReady low holds all outputs stable indefinitely.
- Timing and counting rules:
  - Latency from burst start to first ByteValid: 4 cycles (REQ_LO, REQ_HI, CAP_HI, PRESENT).
  - Steady state: 1 byte per 4 cycles when ByteReady is held high.
  - FifoRdReq is never asserted while FifoEmpty = 1.
  - At most 2*Count nibbles are read per burst.
  - Flush is sampled only in IDLE. Deasserting Flush mid-burst has no effect.
  - UsedW changes during a burst (concurrent writes) do not alter Count.
  - Count width: clog2(BURST_LEN+1); no wrap is possible.

Optional Feature:
- Macro: DRAIN_TIMEOUT_EN.
- With it defined:
  - An idle counter increments each IDLE cycle while 0 < UsedW < THRESH and Flush = 0.
  - Reaching TIMEOUT starts a burst exactly as Flush would.
  - The counter clears on any burst start, on UsedW == 0, and on reset.
- Without it: no counter logic exists, and only THRESH or Flush start bursts.

Decomposition:
- Shared package fifo_drain_pkg holds:
  - state enum (IDLE, REQ_LO, REQ_HI, CAP_HI, CAP_LO, PRESENT);
  - NIB_W = 4 and BYTE_W = 8;
  - a count-width function.
- One sub-module, fifo_drain_pack: the nibble capture registers plus the output byte register with valid/ready hold.
- The FSM and counter stay in the top module.

Test Plan:
- Threshold burst: write 32 nibbles 0..F,0..F, ByteReady = 1.
  - Expect 16 bytes 8'h10, 8'h32, ..., 8'hFE; ByteLast only on the 16th.
  - Expect first ByteValid 4 cycles after start; UsedW ends at 0.
- Odd flush: 3 nibbles A,B,C, then pulse Flush.
  - Expect bytes 8'hBA then 8'h0C, ByteLast on 8'h0C.
  - Expect exactly 3 RdReq pulses, none while Empty.
- Backpressure: ByteReady held 0 for 10 cycles in PRESENT.
  - Expect ByteOut/ByteValid/ByteLast stable, FifoRdReq 0 throughout.
  - Release ByteReady: burst resumes.
- Async reset mid-burst: assert Aclr_n low during REQ_HI of byte 5.
  - Expect all outputs 0 immediately; state IDLE after release.
  - Expect no RdReq until a new start condition.
- Empty stall: external FIFO clear during a burst forces Empty = 1.
  - Expect the block to stall in REQ_LO/REQ_HI with RdReq 0.
  - Expect it to resume on refill without a duplicated nibble.
- DRAIN_TIMEOUT_EN: 5 nibbles, no Flush.
  - Expect a burst start after exactly 64 IDLE cycles with 3 bytes, the last padded 8'h0X.
  - Without the macro: no output.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and helpers for the nibble-FIFO drain controller.
`default_nettype none

package fifo_drain_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        REQ_HI  = 3'd2,
        CAP_HI  = 3'd3,
        CAP_LO  = 3'd4,
        PRESENT = 3'd5
    } drain_state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_drain_pack.sv
// fifo_drain_pack: nibble capture and output byte register with valid/ready hold.
`default_nettype none

module fifo_drain_pack
    import fifo_drain_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIB_W-1:0]  nib,
    input  logic              cap_lo,
    input  logic              load_pair,
    input  logic              load_odd,
    input  logic              last_in,
    input  logic              ready,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    output logic              byte_last
);

    logic [NIB_W-1:0] lo_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_nib     <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
        end else begin
            if (cap_lo) begin
                lo_nib <= nib;
            end
            // The high (or lone) nibble goes straight from the FIFO into the byte.
            if (load_pair) begin
                byte_data  <= {nib, lo_nib};
                byte_valid <= 1'b1;
                byte_last  <= last_in;
            end else if (load_odd) begin
                byte_data  <= {{NIB_W{1'b0}}, nib};
                byte_valid <= 1'b1;
                byte_last  <= last_in;
            end else if (byte_valid && ready) begin
                byte_valid <= 1'b0;
                byte_last  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_nibble_drain.sv
// fifo_nibble_drain: drains a 4-bit LPM FIFO into bursts of packed bytes.
// Optional idle auto-flush enabled by defining DRAIN_TIMEOUT_EN.
`default_nettype none

module fifo_nibble_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int AW        = 8,
    parameter int BURST_LEN = 16,
    parameter int THRESH    = 32
`ifdef DRAIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 64
`endif
) (
    input  logic              Clock,
    input  logic              Aclr_n,
    input  logic [WIDTH-1:0]  FifoQ,
    input  logic              FifoEmpty,
    input  logic [AW-1:0]     FifoUsedW,
    output logic              FifoRdReq,
    input  logic              Flush,
    output logic [BYTE_W-1:0] ByteOut,
    output logic              ByteValid,
    input  logic              ByteReady,
    output logic              ByteLast,
    output logic              Busy
);

    localparam int CW = cnt_width(BURST_LEN);

    localparam logic [AW:0]   THRESH_V    = (AW+1)'(THRESH);
    localparam logic [AW:0]   BURST_V     = (AW+1)'(BURST_LEN);
    localparam logic [AW:0]   TWO_BURST_V = (AW+1)'(2 * BURST_LEN);
    localparam logic [CW-1:0] BURST_C     = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE_C       = CW'(1);

    drain_state_t  state;
    logic [CW-1:0] count;
    logic          odd;
    logic          rd_d;

    logic [AW:0]   used_ext;
    logic [AW:0]   half_up;
    logic [CW-1:0] flush_cnt;
    logic          flush_odd;
    logic          above_thresh;
    logic          timeout_hit;
    logic          drain_req;
    logic          rd_req;
    logic          last_byte;

    assign used_ext     = {1'b0, FifoUsedW};
    assign half_up      = (used_ext + 1'b1) >> 1;
    assign flush_cnt    = (half_up >= BURST_V) ? BURST_C : CW'(half_up);
    assign flush_odd    = (used_ext < TWO_BURST_V) && FifoUsedW[0];
    assign above_thresh = (used_ext >= THRESH_V);
    assign drain_req    = (Flush || timeout_hit) && (FifoUsedW != '0);
    assign last_byte    = (count == ONE_C);

    assign rd_req    = ((state == REQ_LO) || (state == REQ_HI)) && !FifoEmpty;
    assign FifoRdReq = rd_req;

`ifdef DRAIN_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT);

    logic [TW-1:0] idle_cnt;
    logic          idle_count_en;

    assign idle_count_en = (state == IDLE) && (FifoUsedW != '0) && !above_thresh && !Flush;
    assign timeout_hit   = idle_count_en && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            idle_cnt <= '0;
        end else if ((state == IDLE) && (above_thresh || drain_req)) begin
            idle_cnt <= '0;
        end else if (FifoUsedW == '0) begin
            idle_cnt <= '0;
        end else if (idle_count_en) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Aclr_n) begin
        if (!Aclr_n) begin
            state <= IDLE;
            count <= '0;
            odd   <= 1'b0;
            rd_d  <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            rd_d <= rd_req;
            case (state)
                IDLE: begin
                    if (above_thresh) begin
                        count <= BURST_C;
                        odd   <= 1'b0;
                        state <= REQ_LO;
                        Busy  <= 1'b1;
                    end else if (drain_req) begin
                        count <= flush_cnt;
                        odd   <= flush_odd;
                        state <= REQ_LO;
                        Busy  <= 1'b1;
                    end
                end
                REQ_LO: begin
                    if (!FifoEmpty) begin
                        state <= (last_byte && odd) ? CAP_LO : REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (!FifoEmpty) begin
                        state <= CAP_HI;
                    end
                end
                CAP_HI, CAP_LO: begin
                    state <= PRESENT;
                end
                PRESENT: begin
                    if (ByteValid && ByteReady) begin
                        count <= count - 1'b1;
                        if (last_byte) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            state <= REQ_LO;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Low nibble arrives the cycle after its read; a stalled REQ_HI keeps the first capture.
    fifo_drain_pack u_pack (
        .clk        (Clock),
        .rst_n      (Aclr_n),
        .nib        (FifoQ),
        .cap_lo     ((state == REQ_HI) && rd_d),
        .load_pair  (state == CAP_HI),
        .load_odd   (state == CAP_LO),
        .last_in    (last_byte),
        .ready      (ByteReady),
        .byte_data  (ByteOut),
        .byte_valid (ByteValid),
        .byte_last  (ByteLast)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_nibble_drain.sv
// tb_fifo_nibble_drain: randomized bench with a FIFO model and a byte-stream reference.
`default_nettype none

module tb_fifo_nibble_drain;

    localparam int BURST_LEN = 16;
    localparam int THRESH    = 32;
    localparam int TIMEOUT   = 64;

    logic       Clock = 1'b0;
    logic       Aclr_n = 1'b0;
    logic [3:0] FifoQ;
    logic       FifoEmpty;
    logic [7:0] FifoUsedW;
    logic       FifoRdReq;
    logic       Flush = 1'b0;
    logic [7:0] ByteOut;
    logic       ByteValid;
    logic       ByteReady = 1'b0;
    logic       ByteLast;
    logic       Busy;

    always #5 Clock = ~Clock;

    // Behavioural FIFO: registered read data, combinational flags.
    logic [3:0] mem [0:255];
    logic [8:0] wp = '0;
    logic [8:0] rp = '0;
    logic [3:0] fifo_q = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = '0;
    logic       fclr = 1'b0;

    assign FifoQ     = fifo_q;
    assign FifoEmpty = (wp == rp);
    assign FifoUsedW = 8'(wp - rp);

    always @(posedge Clock) begin
        if (fclr) begin
            rp <= wp;
        end else if (FifoRdReq && !FifoEmpty) begin
            fifo_q <= mem[rp[7:0]];
            rp     <= rp + 9'd1;
        end
        if (wr_en) begin
            mem[wp[7:0]] <= wr_data;
            wp           <= wp + 9'd1;
        end
    end

    fifo_nibble_drain dut (
        .Clock     (Clock),
        .Aclr_n    (Aclr_n),
        .FifoQ     (FifoQ),
        .FifoEmpty (FifoEmpty),
        .FifoUsedW (FifoUsedW),
        .FifoRdReq (FifoRdReq),
        .Flush     (Flush),
        .ByteOut   (ByteOut),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .ByteLast  (ByteLast),
        .Busy      (Busy)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int rd_pulses   = 0;
    int rd_on_empty = 0;
    bit rnd_ready   = 1'b0;

    logic [7:0] got_bytes[$];
    bit         got_last[$];
    int         got_cyc[$];
    logic [3:0] exp_nibs[$];
    logic [7:0] exp_bytes[$];
    bit         exp_last[$];

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        #2;
        if (Aclr_n) begin
            if (ByteValid && ByteReady) begin
                got_bytes.push_back(ByteOut);
                got_last.push_back(ByteLast);
                got_cyc.push_back(cyc);
            end
            if (FifoRdReq) begin
                rd_pulses++;
                if (FifoEmpty) rd_on_empty++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        if (rnd_ready) ByteReady = ($urandom_range(0, 3) != 0);
    endtask

    task automatic put_nib(input logic [3:0] v);
        tick();
        wr_en   = 1'b1;
        wr_data = v;
        exp_nibs.push_back(v);
    endtask

    task automatic put_done();
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
    endtask

    // Pack consecutive nibbles low-first; an odd burst ends on a zero-padded byte.
    task automatic expect_bytes(input int cnt, input bit odd);
        logic [3:0] lo, hi;
        for (int i = 0; i < cnt; i++) begin
            lo = exp_nibs.pop_front();
            if (odd && i == cnt - 1) begin
                exp_bytes.push_back({4'h0, lo});
            end else begin
                hi = exp_nibs.pop_front();
                exp_bytes.push_back({hi, lo});
            end
            exp_last.push_back(i == cnt - 1);
        end
    endtask

    task automatic predict_burst(input int used);
        int cnt;
        bit odd;
        if (used >= THRESH) begin
            cnt = BURST_LEN;
            odd = 1'b0;
        end else begin
            cnt = (used + 1) / 2;
            if (cnt > BURST_LEN) cnt = BURST_LEN;
            odd = (used < 2 * BURST_LEN) && (used % 2 == 1);
        end
        expect_bytes(cnt, odd);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (got_bytes.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq({tag, "_arrived"}, 32'(got_bytes.size() >= n), 32'd1);
        repeat (6) tick();
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
            check_eq($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
        end
        got_bytes.delete();
        got_last.delete();
        got_cyc.delete();
        exp_bytes.delete();
        exp_last.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] saved[$];
        logic [7:0] held_byte;
        bit         held_last;
        int         lat, unstable, t0, n;
        bit         busy_seen;

        // Reset state
        repeat (3) tick();
        check_eq("rst_rdreq", FifoRdReq, 0);
        check_eq("rst_valid", ByteValid, 0);
        check_eq("rst_last",  ByteLast,  0);
        check_eq("rst_busy",  Busy,      0);
        check_eq("rst_byte",  ByteOut,   8'h00);
        Aclr_n = 1'b1;
        repeat (2) tick();
        check_eq("post_rst_busy", Busy, 0);

        // Threshold burst with the fixed ramp pattern
        ByteReady = 1'b1;
        rd_pulses = 0;
        for (int i = 0; i < 32; i++) put_nib(4'(i % 16));
        put_done();
        check_eq("thr_usedw_start", FifoUsedW, 32);
        lat = 0;
        while (!ByteValid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("thr_latency", lat, 4);
        predict_burst(32);
        wait_bytes(16, 100, "thr");
        check_eq("thr_spacing", (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1, 4);
        compare_stream("thr");
        check_eq("thr_usedw_end", FifoUsedW, 0);
        check_eq("thr_rdreq_cnt", rd_pulses, 32);
        check_eq("thr_busy_end", Busy, 0);

        // Odd flush: A,B,C
        rd_pulses = 0;
        put_nib(4'hA); put_nib(4'hB); put_nib(4'hC);
        put_done();
        pulse_flush();
        predict_burst(3);
        wait_bytes(2, 40, "odd");
        compare_stream("odd");
        check_eq("odd_rdreq_cnt", rd_pulses, 3);
        check_eq("odd_busy_end", Busy, 0);

        // Flush with nothing buffered must not start
        rd_pulses = 0;
        Flush = 1'b1;
        repeat (5) tick();
        Flush = 1'b0;
        check_eq("empty_flush_busy", Busy, 0);
        check_eq("empty_flush_rdreq", rd_pulses, 0);

        // Randomized flush bursts under random backpressure
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? 31 : (it == 1) ? 1 : $urandom_range(1, 31);
            for (int i = 0; i < n; i++) put_nib(4'($urandom_range(0, 15)));
            put_done();
            rnd_ready = 1'b1;
            pulse_flush();
            predict_burst(n);
            wait_bytes(exp_bytes.size(), 400, $sformatf("rnd%0d", it));
            rnd_ready = 1'b0;
            ByteReady = 1'b1;
            repeat (4) tick();
            compare_stream($sformatf("rnd%0d", it));
            check_eq($sformatf("rnd%0d_usedw", it), FifoUsedW, 0);
            check_eq($sformatf("rnd%0d_busy", it), Busy, 0);
        end

        // Backpressure: hold ByteReady low for 10 cycles in PRESENT
        ByteReady = 1'b0;
        for (int i = 0; i < 32; i++) put_nib(4'($urandom_range(0, 15)));
        put_done();
        predict_burst(32);
        lat = 0;
        while (!ByteValid && lat < 20) begin
            tick();
            lat++;
        end
        held_byte = ByteOut;
        held_last = ByteLast;
        unstable  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ByteOut !== held_byte || ByteValid !== 1'b1 || ByteLast !== held_last || FifoRdReq !== 1'b0)
                unstable++;
        end
        check_eq("bp_stable", unstable, 0);
        check_eq("bp_held_valid", ByteValid, 1);
        ByteReady = 1'b1;
        wait_bytes(16, 100, "bp");
        compare_stream("bp");

        // Async reset during REQ_HI of byte 5
        rd_pulses = 0;
        for (int i = 0; i < 32; i++) put_nib(4'($urandom_range(0, 15)));
        put_done();
        saved = exp_nibs;
        predict_burst(32);
        while (exp_bytes.size() > 4) begin
            void'(exp_bytes.pop_back());
            void'(exp_last.pop_back());
        end
        lat = 0;
        while (got_bytes.size() < 4 && lat < 60) begin
            tick();
            lat++;
        end
        tick();
        #1 Aclr_n = 1'b0;
        #1;
        check_eq("arst_rdreq", FifoRdReq, 0);
        check_eq("arst_valid", ByteValid, 0);
        check_eq("arst_last",  ByteLast,  0);
        check_eq("arst_busy",  Busy,      0);
        check_eq("arst_byte",  ByteOut,   8'h00);
        check_eq("arst_reads", rd_pulses, 9);
        compare_stream("arst_pre");
        tick();
        tick();
        Aclr_n = 1'b1;
        rd_pulses = 0;
        exp_nibs = saved;
        repeat (9) void'(exp_nibs.pop_front());
        check_eq("arst_usedw", FifoUsedW, 23);
        repeat (10) tick();
        check_eq("arst_idle_rdreq", rd_pulses, 0);
        check_eq("arst_idle_busy", Busy, 0);
        pulse_flush();
        predict_burst(23);
        wait_bytes(12, 100, "arst_post");
        compare_stream("arst_post");

        // Empty stall: FIFO cleared mid-burst, then refilled slowly
        ByteReady = 1'b0;
        for (int i = 0; i < 10; i++) put_nib(4'($urandom_range(0, 15)));
        put_done();
        pulse_flush();
        predict_burst(10);
        while (exp_bytes.size() > 1) begin
            void'(exp_bytes.pop_back());
            void'(exp_last.pop_back());
        end
        lat = 0;
        while (!ByteValid && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        fclr = 1'b1;
        tick();
        fclr = 1'b0;
        exp_nibs.delete();
        ByteReady = 1'b1;
        wait_bytes(1, 20, "stall_first");
        compare_stream("stall_first");
        repeat (15) tick();
        check_eq("stall_no_bytes", got_bytes.size(), 0);
        check_eq("stall_busy", Busy, 1);
        for (int i = 0; i < 8; i++) begin
            put_nib(4'($urandom_range(0, 15)));
            put_done();
            repeat (3) tick();
        end
        expect_bytes(4, 1'b0);
        wait_bytes(4, 100, "stall_resume");
        compare_stream("stall_resume");
        check_eq("stall_usedw", FifoUsedW, 0);
        check_eq("stall_busy_end", Busy, 0);

        // Idle auto-flush (or its absence)
        busy_seen = 1'b0;
        put_nib(4'($urandom_range(0, 15)));
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) put_nib(4'($urandom_range(0, 15)));
        put_done();
`ifdef DRAIN_TIMEOUT_EN
        lat = 0;
        while (!Busy && lat < 200) begin
            tick();
            lat++;
        end
        check_eq("tmo_start_delay", cyc - t0, TIMEOUT);
        predict_burst(5);
        wait_bytes(3, 60, "tmo");
        compare_stream("tmo");
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (Busy) busy_seen = 1'b1;
        end
        check_eq("notmo_busy", busy_seen, 0);
        check_eq("notmo_bytes", got_bytes.size(), 0);
        check_eq("notmo_usedw", FifoUsedW, 5);
        check_eq("notmo_elapsed", 32'(cyc - t0 > 100), 1);
        pulse_flush();
        predict_burst(5);
        wait_bytes(3, 60, "notmo_drain");
        compare_stream("notmo_drain");
`endif
        check_eq("no_rdreq_on_empty", rd_on_empty, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
